// File: rtl/rtc_timekeeper.sv
`default_nettype none
// ============================================================================
// Module   : rtc_timekeeper
// Purpose  : Time-of-day counter (hh:mm:ss) running from the system clock.
//            An internal prescaler derives the 1 s tick. Provides run/stop,
//            range-checked time load, 12/24 h display, a sticky hh:mm alarm
//            and second/day strobes.
// Ports    : clk_sys, sys_rsn (sync active-low reset)
//            run, mode_12h                   - control
//            set_vld/set_hour/set_min/set_s  - time load, set_err on reject
//            alarm_en/alarm_hour/alarm_min/alarm_clr, alarm_flag
//            hour (display), min, s, pm      - time outputs
//            sec_pulse, day_pulse            - one-cycle strobes
// Revision : 1.0 - initial release
// ============================================================================
module rtc_timekeeper #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int PRESC_W = $clog2(CLK_HZ)
) (
    input  logic       clk_sys,
    input  logic       sys_rsn,
    input  logic       run,
    input  logic       mode_12h,
    input  logic       set_vld,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [5:0] set_s,
    output logic       set_err,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_clr,
    output logic       alarm_flag,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] s,
    output logic       pm,
    output logic       sec_pulse,
    output logic       day_pulse
);

    localparam logic [PRESC_W-1:0] C_PRESC_MAX = PRESC_W'(CLK_HZ - 1);

    logic [PRESC_W-1:0] r_presc;
    logic [4:0]         r_hour24;
    logic [5:0]         r_min;
    logic [5:0]         r_s;
    logic               r_set_err;
    logic               r_alarm_flag;
    logic               r_sec_pulse;
    logic               r_day_pulse;

    logic       w_tick;
    logic       w_set_ok;
    logic       w_load;
    logic       w_s_wrap;
    logic       w_min_wrap;
    logic       w_hour_wrap;
    logic [5:0] w_s_next;
    logic [5:0] w_min_next;
    logic [4:0] w_hour_next;
    logic       w_day_wrap;
    logic       w_alarm_hit;
    logic [4:0] w_hour_disp;

    assign w_tick   = run && (r_presc == C_PRESC_MAX);
    assign w_set_ok = (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_s <= 6'd59);
    assign w_load   = set_vld && w_set_ok;

    // Successor time, used only when a tick is taken
    assign w_s_wrap    = (r_s == 6'd59);
    assign w_min_wrap  = (r_min == 6'd59);
    assign w_hour_wrap = (r_hour24 == 5'd23);
    assign w_s_next    = w_s_wrap ? 6'd0 : r_s + 6'd1;
    assign w_min_next  = !w_s_wrap ? r_min : (w_min_wrap ? 6'd0 : r_min + 6'd1);
    assign w_hour_next = !(w_s_wrap && w_min_wrap) ? r_hour24 :
                         (w_hour_wrap ? 5'd0 : r_hour24 + 5'd1);
    assign w_day_wrap  = w_s_wrap && w_min_wrap && w_hour_wrap;

    // Compare against the time about to be shown, so the flag rises together
    // with the matching time. Out-of-range alarm fields can never equal it.
    assign w_alarm_hit = alarm_en && (w_hour_next == alarm_hour) &&
                         (w_min_next == alarm_min) && (w_s_next == 6'd0);

    always_ff @(posedge clk_sys) begin
        if (!sys_rsn) begin
            r_presc      <= '0;
            r_hour24     <= 5'd0;
            r_min        <= 6'd0;
            r_s          <= 6'd0;
            r_set_err    <= 1'b0;
            r_alarm_flag <= 1'b0;
            r_sec_pulse  <= 1'b0;
            r_day_pulse  <= 1'b0;
        end else begin
            r_set_err   <= set_vld && !w_set_ok;
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;

            // A valid load swallows any coincident tick
            if (w_load) begin
                r_presc  <= '0;
                r_hour24 <= set_hour;
                r_min    <= set_min;
                r_s      <= set_s;
            end else if (w_tick) begin
                r_presc     <= '0;
                r_hour24    <= w_hour_next;
                r_min       <= w_min_next;
                r_s         <= w_s_next;
                r_sec_pulse <= 1'b1;
                r_day_pulse <= w_day_wrap;
            end else if (run) begin
                r_presc <= r_presc + 1'b1;
            end

            // Set has priority over clear
            if (!w_load && w_tick && w_alarm_hit) begin
                r_alarm_flag <= 1'b1;
            end else if (alarm_clr) begin
                r_alarm_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        w_hour_disp = r_hour24;
        if (mode_12h) begin
            if (r_hour24 == 5'd0) begin
                w_hour_disp = 5'd12;
            end else if (r_hour24 > 5'd12) begin
                w_hour_disp = r_hour24 - 5'd12;
            end
        end
    end

    assign hour       = w_hour_disp;
    assign pm         = (r_hour24 >= 5'd12);
    assign min        = r_min;
    assign s          = r_s;
    assign set_err    = r_set_err;
    assign alarm_flag = r_alarm_flag;
    assign sec_pulse  = r_sec_pulse;
    assign day_pulse  = r_day_pulse;

endmodule
`default_nettype wire

// File: tb/tb_rtc_timekeeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_timekeeper
// Purpose  : Self-checking bench for rtc_timekeeper (CLK_HZ = 4). A model
//            based on seconds-of-day is compared with the DUT every cycle,
//            alongside directed checks with hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_timekeeper;

    localparam int CLK_HZ = 4;

    logic       clk_sys = 1'b0;
    logic       sys_rsn = 1'b0;
    logic       run = 1'b0;
    logic       mode_12h = 1'b0;
    logic       set_vld = 1'b0;
    logic [4:0] set_hour = 5'd0;
    logic [5:0] set_min = 6'd0;
    logic [5:0] set_s = 6'd0;
    logic       set_err;
    logic       alarm_en = 1'b0;
    logic [4:0] alarm_hour = 5'd0;
    logic [5:0] alarm_min = 6'd0;
    logic       alarm_clr = 1'b0;
    logic       alarm_flag;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] s;
    logic       pm;
    logic       sec_pulse;
    logic       day_pulse;

    rtc_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
        .clk_sys    (clk_sys),
        .sys_rsn    (sys_rsn),
        .run        (run),
        .mode_12h   (mode_12h),
        .set_vld    (set_vld),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .set_s      (set_s),
        .set_err    (set_err),
        .alarm_en   (alarm_en),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_clr  (alarm_clr),
        .alarm_flag (alarm_flag),
        .hour       (hour),
        .min        (min),
        .s          (s),
        .pm         (pm),
        .sec_pulse  (sec_pulse),
        .day_pulse  (day_pulse)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- model: time held as seconds of the day ----------------
    int m_tod   = 0;   // seconds since midnight
    int m_cyc   = 0;   // cycles elapsed in the current second
    bit m_err   = 0;
    bit m_flag  = 0;
    bit m_sp    = 0;
    bit m_dp    = 0;
    bit m_tick;
    bit m_ok;
    bit m_hit;

    always @(posedge clk_sys) begin
        if (!sys_rsn) begin
            m_tod = 0; m_cyc = 0; m_err = 0; m_flag = 0; m_sp = 0; m_dp = 0;
        end else begin
            m_tick = run && (m_cyc == CLK_HZ - 1);
            m_ok   = (set_hour < 24) && (set_min < 60) && (set_s < 60);
            m_err  = set_vld && !m_ok;
            m_sp   = 0;
            m_dp   = 0;
            m_hit  = 0;
            if (set_vld && m_ok) begin
                m_tod = int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_s);
                m_cyc = 0;
            end else if (m_tick) begin
                m_tod = (m_tod + 1) % 86400;
                m_cyc = 0;
                m_sp  = 1;
                m_dp  = (m_tod == 0);
                m_hit = alarm_en && alarm_hour < 24 && alarm_min < 60 &&
                        m_tod == int'(alarm_hour) * 3600 + int'(alarm_min) * 60;
            end else if (run) begin
                m_cyc++;
            end
            if (m_hit) m_flag = 1;
            else if (alarm_clr) m_flag = 0;
        end
    end

    function automatic int disp_hour(input int tod, input bit m12);
        int h;
        h = tod / 3600;
        if (!m12) return h;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    always @(negedge clk_sys) begin
        #2;
        if (chk_en) begin
            chk("m_hour", int'(hour), disp_hour(m_tod, mode_12h));
            chk("m_min", int'(min), (m_tod / 60) % 60);
            chk("m_s", int'(s), m_tod % 60);
            chk("m_pm", int'(pm), int'(m_tod >= 12 * 3600));
            chk("m_sec_pulse", int'(sec_pulse), int'(m_sp));
            chk("m_day_pulse", int'(day_pulse), int'(m_dp));
            chk("m_set_err", int'(set_err), int'(m_err));
            chk("m_alarm_flag", int'(alarm_flag), int'(m_flag));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic load(input int h, input int m, input int sec);
        set_hour = 5'(h);
        set_min  = 6'(m);
        set_s    = 6'(sec);
        set_vld  = 1'b1;
        @(negedge clk_sys);
        set_vld  = 1'b0;
    endtask

    int dp_cnt;

    initial begin
        // reset state
        @(negedge clk_sys);
        chk_en = 1'b1;
        chk("rst_s", int'(s), 0);
        chk("rst_min", int'(min), 0);
        chk("rst_hour", int'(hour), 0);
        chk("rst_pm", int'(pm), 0);
        chk("rst_sec_pulse", int'(sec_pulse), 0);
        chk("rst_alarm_flag", int'(alarm_flag), 0);
        mode_12h = 1'b1;
        #1 chk("rst_hour12", int'(hour), 12);
        mode_12h = 1'b0;

        // first tick and minute rollover
        @(negedge clk_sys);
        sys_rsn = 1'b1;
        run     = 1'b1;
        cyc(3); chk("pre_tick_s", int'(s), 0);
        cyc(1); chk("tick1_s", int'(s), 1); chk("tick1_sp", int'(sec_pulse), 1);
        cyc(236); chk("c240_min", int'(min), 1); chk("c240_s", int'(s), 0);

        // run=0 freezes everything
        run = 1'b0;
        cyc(10); chk("stop_s", int'(s), 0); chk("stop_min", int'(min), 1);
        run = 1'b1;
        cyc(3); chk("resume_pre_s", int'(s), 0);
        cyc(1); chk("resume_s", int'(s), 1);

        // day rollover
        load(23, 59, 58);
        chk("day_load_h", int'(hour), 23); chk("day_load_pm", int'(pm), 1);
        dp_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            dp_cnt += int'(day_pulse);
            if (i == 4) chk("day_s59", int'(s), 59);
        end
        chk("day_cnt", dp_cnt, 1);
        chk("day_dp", int'(day_pulse), 1);
        chk("day_sp", int'(sec_pulse), 1);
        chk("day_hour", int'(hour), 0);
        chk("day_s", int'(s), 0);
        chk("day_pm", int'(pm), 0);

        // 12 h display
        run = 1'b0;
        mode_12h = 1'b1;
        load(0, 0, 0);  chk("m12_0_h", int'(hour), 12); chk("m12_0_pm", int'(pm), 0);
        load(12, 0, 0); chk("m12_12_h", int'(hour), 12); chk("m12_12_pm", int'(pm), 1);
        load(13, 5, 0); chk("m12_13_h", int'(hour), 1); chk("m12_13_pm", int'(pm), 1);
        mode_12h = 1'b0;
        #1 chk("m24_13_h", int'(hour), 13); chk("m24_13_min", int'(min), 5);

        // rejected loads
        load(24, 0, 0);
        chk("err24", int'(set_err), 1); chk("err24_h", int'(hour), 13);
        cyc(1); chk("err_clear", int'(set_err), 0);
        load(10, 60, 0);
        chk("err60", int'(set_err), 1); chk("err60_min", int'(min), 5);

        // load coincident with tick
        run = 1'b1;
        cyc(3);
        load(10, 0, 0);
        chk("lt_hour", int'(hour), 10); chk("lt_s", int'(s), 0);
        chk("lt_sp", int'(sec_pulse), 0);
        cyc(3); chk("lt_pre_s", int'(s), 0);
        cyc(1); chk("lt_tick_s", int'(s), 1); chk("lt_tick_sp", int'(sec_pulse), 1);

        // alarm
        run = 1'b0;
        alarm_en = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
        load(7, 29, 59);
        run = 1'b1;
        cyc(3); chk("al_pre", int'(alarm_flag), 0);
        cyc(1); chk("al_set", int'(alarm_flag), 1); chk("al_min", int'(min), 30);
        chk("al_s", int'(s), 0);
        alarm_clr = 1'b1; cyc(1); alarm_clr = 1'b0;
        chk("al_clr", int'(alarm_flag), 0);
        load(7, 30, 0); chk("al_load", int'(alarm_flag), 0);
        load(7, 29, 59);
        cyc(3);
        alarm_clr = 1'b1; cyc(1); alarm_clr = 1'b0;
        chk("al_setwins", int'(alarm_flag), 1);
        alarm_en = 1'b0;
        cyc(1); chk("al_en0_hold", int'(alarm_flag), 1);

        // reset mid-count
        load(5, 17, 42);
        cyc(2);
        sys_rsn = 1'b0;
        #1 chk("mr_pre_s", int'(s), 42);
        cyc(1);
        chk("mr_s", int'(s), 0); chk("mr_min", int'(min), 0);
        chk("mr_hour", int'(hour), 0); chk("mr_flag", int'(alarm_flag), 0);
        sys_rsn = 1'b1;
        cyc(3); chk("mr_pre_tick", int'(s), 0);
        cyc(1); chk("mr_tick", int'(s), 1);

        cyc(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
- Parametrised time-of-day counter; successor to the fixed 1 Hz hour/min/s counter.
- Runs on the system clock, with an internal prescaler generating the 1 s tick.
- Adds run/stop control, validated time load, a runtime 12/24 h display mode, a sticky hh:mm alarm, and second/day strobes.
- Feeds display drivers and the interrupt/status logic.

Parameters:
- CLK_HZ, 50_000_000, clk_sys cycles per second; must be ≥2. Benches use 4.
- PRESC_W, $clog2(CLK_HZ), prescaler width; derived, not overridden.

Ports:
- clk_sys  in  1  system clock; the only clock.
- sys_rsn  in  1  synchronous active-low reset, sampled on the clk_sys rising edge.
- run  in  1  1 = timekeeping advances; 0 = prescaler and time frozen.
- mode_12h  in  1  0 = 24 h display, 1 = 12 h display.
- set_vld  in  1  one-cycle load strobe.
- set_hour  in  5  load hour, 0..23.
- set_min  in  6  load minute, 0..59.
- set_s  in  6  load second, 0..59.
- set_err  out  1  one-cycle pulse: load rejected (out of range).
- alarm_en  in  1  alarm compare enable.
- alarm_hour  in  5  alarm hour, 24 h format.
- alarm_min  in  6  alarm minute.
- alarm_clr  in  1  clears alarm_flag.
- alarm_flag  out  1  sticky alarm status.
- hour  out  5  displayed hour.
- min  out  6  minute, 0..59.
- s  out  6  second, 0..59.
- pm  out  1  1 when the internal 24 h hour is ≥12.
- sec_pulse  out  1  one-cycle strobe on each second update.
- day_pulse  out  1  one-cycle strobe on 23:59:59 → 00:00:00.

Behaviour:
- Reset: when sys_rsn=0 at a clk_sys edge:
  - prescaler, hour24, min and s = 0;
  - set_err, alarm_flag, sec_pulse and day_pulse = 0.
  - There is no asynchronous path; a reset mid-count takes effect only at the next edge.
  - After reset: hour=0 (mode_12h=0) or 12 (mode_12h=1), pm=0.
- Prescaler:
  - Counts 0..CLK_HZ-1 while run=1.
  - tick = run && presc==CLK_HZ-1; presc then wraps to 0.
  - While run=0, presc holds and no tick occurs.
  - First tick arrives CLK_HZ cycles after run rises from a reset or load state.
- Time advance on tick (registered; new value visible the cycle after the tick edge):
  - s: 59→0 with carry, else +1.
  - min: advances only on an s carry; 59→0 with carry.
  - hour24: advances only on a min carry; 23→0.
  - All arithmetic is unsigned at the native widths. No value outside its range is ever stored.
- Strobes:
  - sec_pulse: registered, high for exactly the one cycle in which the updated s is first visible.
  - day_pulse: registered, same timing, only on the 23:59:59→00:00:00 tick.
- Load (set_vld=1):
  - Valid when set_hour≤23, set_min≤59 and set_s≤59. Then hour24/min/s take the set values next cycle and presc clears to 0.
  - Load has priority over a coincident tick: the tick is discarded, with no sec_pulse and no day_pulse.
  - Invalid: time and presc are unchanged (presc continues counting and a coincident tick proceeds normally). set_err pulses for one cycle.
  - Load is accepted regardless of run.
- Display:
  - hour and pm are combinational from the registered hour24 and mode_12h.
  - mode_12h=0: hour=hour24.
  - mode_12h=1: hour24 0→12, 1..12→unchanged, 13..23→hour24-12.
  - pm = (hour24≥12) in both modes.
  - Changing mode_12h never alters the internal state.
- Alarm:
  - Set condition: a tick-driven update whose new time equals alarm_hour:alarm_min:00 while alarm_en=1. alarm_flag then rises in the same cycle the new time becomes visible.
  - Loads never trigger the alarm.
  - alarm_clr=1 clears the flag next cycle.
  - A set and clr in the same cycle: set wins.
  - alarm_en=0 blocks setting but does not clear an existing flag.
  - Out-of-range alarm fields simply never match.
- Timing: no combinational path from inputs to registered outputs; hour and pm are the only combinational outputs.

Test Plan (CLK_HZ=4):
- Reset, then run=1 from cycle 0 → s=1 and sec_pulse=1 on cycle 4. After 240 cycles min=1, s=0. Hold run=0 for 10 cycles → s, min and presc frozen.
- Load 23:59:58 with run=1, then wait 8 cycles → 23:59:59, then 00:00:00. day_pulse fires exactly once, with sec_pulse; pm goes 1→0.
- mode_12h=1: load 00:00:00 → hour=12, pm=0. Load 12:00:00 → hour=12, pm=1. Load 13:05:00 → hour=1, pm=1. Toggle mode → hour=13 without a time change.
- set_vld with 24:00:00, then 10:60:00 → set_err pulses each time, time unchanged. set_vld with 10:00:00 on a tick cycle → time=10:00:00, no sec_pulse, next tick 4 cycles later.
- alarm_en=1, alarm 07:30; load 07:29:59; tick → 07:30:00 and alarm_flag=1 in the same cycle. Then:
  - load 07:30:00 → no new set;
  - alarm_clr alone → flag=0;
  - alarm_clr coincident with a matching tick → flag stays 1.
- Reset with run=1 mid-count (time 05:17:42): sys_rsn low in one cycle → all outputs 0 only after the next clk_sys edge. Deasserting → counting restarts with the first tick 4 cycles later.
